// File: rtl/dac_seq_pkg.sv
// Shared types and defaults for the DAC sample sequencer: state encoding,
// default widths and the position of the I and Q words inside a packed pair.
package dac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_I = 2'd1,
    EMIT_Q = 2'd2
  } seq_state_e;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DEF_DIV_WIDTH  = 16;
  localparam int DEF_CNT_WIDTH  = 16;

  // A pair is an ascending [0:2*W-1] vector: slot 0 holds I, slot 1 holds Q.
  localparam int SMP_I_SLOT = 0;
  localparam int SMP_Q_SLOT = 1;

  function automatic int smp_slot_lo(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/dac_seq_fifo.sv
// Synchronous first-word-fall-through FIFO for packed I/Q pairs.
// Writes while full and reads while empty are ignored.
module dac_seq_fifo
  import dac_seq_pkg::*;
#(
  parameter int WIDTH      = 2 * DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [0:WIDTH-1]      wr_data,
  input  logic                  rd_en,
  output logic [0:WIDTH-1]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [0:WIDTH-1]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  do_wr, do_rd;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd)      level_d = level_q + 1'b1;
    else if (do_rd && !do_wr) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Releases buffered I/Q pairs to the DAC at one slot per Cfg_Div+1 clocks,
// with counted or continuous bursts and sticky underrun/overflow status.
//   state  | meaning
//   IDLE   | no burst, divider stopped
//   EMIT_I | next slot emits the I word of a fresh pair
//   EMIT_Q | next slot emits the held Q word
module dac_sample_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                    Bus2IP_Clk,
  input  logic                    Bus2IP_Reset,
  input  logic                    Cfg_Start,
  input  logic                    Cfg_Stop,
  input  logic [DIV_WIDTH-1:0]    Cfg_Div,
  input  logic [CNT_WIDTH-1:0]    Cfg_Count,
  input  logic                    Cfg_Interleave,
  input  logic                    Smp_Wr,
  input  logic [0:2*DATA_WIDTH-1] Smp_Data,
  output logic                    Smp_Full,
  output logic [DEPTH_LOG2:0]     Smp_Level,
  output logic [0:DATA_WIDTH-1]   DAC_Data,
  output logic                    DAC_Strobe,
  output logic                    DAC_Sel,
  output logic                    DAC_En,
  output logic                    Sts_Busy,
  output logic                    Sts_Done,
  output logic                    Sts_Underrun,
  output logic                    Sts_Overflow
);
  localparam int PAIR_W = 2 * DATA_WIDTH;
  localparam int I_LO   = smp_slot_lo(SMP_I_SLOT, DATA_WIDTH);
  localparam int Q_LO   = smp_slot_lo(SMP_Q_SLOT, DATA_WIDTH);

  seq_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d, div_cnt_q, div_cnt_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  cont_q, cont_d, ilv_q, ilv_d, done_pend_q, done_pend_d;
  logic [0:DATA_WIDTH-1] q_hold_q, q_hold_d, dac_data_q, dac_data_d;
  logic                  strobe_q, strobe_d, sel_q, sel_d, en_q, en_d;
  logic                  done_q, done_d, unr_q, unr_d, ovf_q, ovf_d;
  logic                  tick, pair_done;

  logic [0:PAIR_W-1]     fifo_rdata;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DEPTH_LOG2:0]   fifo_level;

  assign fifo_push = Smp_Wr & ~fifo_full;

  dac_seq_fifo #(.WIDTH(PAIR_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(Bus2IP_Clk), .rst(Bus2IP_Reset),
    .wr_en(fifo_push), .wr_data(Smp_Data),
    .rd_en(fifo_pop), .rd_data(fifo_rdata),
    .full(fifo_full), .empty(fifo_empty), .level(fifo_level)
  );

  assign tick = (state_q != IDLE) && (div_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    div_cnt_d   = div_cnt_q;
    rem_d       = rem_q;
    cont_d      = cont_q;
    ilv_d       = ilv_q;
    done_pend_d = done_pend_q;
    q_hold_d    = q_hold_q;
    dac_data_d  = dac_data_q;
    sel_d       = sel_q;
    strobe_d    = 1'b0;
    done_d      = 1'b0;
    unr_d       = unr_q;
    ovf_d       = ovf_q | (Smp_Wr & fifo_full);
    fifo_pop    = 1'b0;
    pair_done   = 1'b0;

    if (state_q != IDLE) div_cnt_d = tick ? div_q : div_cnt_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (Cfg_Start && !Cfg_Stop) begin
          div_d       = Cfg_Div;
          rem_d       = Cfg_Count;
          cont_d      = (Cfg_Count == '0);
          ilv_d       = Cfg_Interleave;
          div_cnt_d   = '0;
          done_pend_d = 1'b0;
          unr_d       = 1'b0;
          ovf_d       = Smp_Wr & fifo_full;
          state_d     = EMIT_I;
        end
      end
      EMIT_I: begin
        // A completed count waits one clock here so Done trails the last strobe.
        if (Cfg_Stop || done_pend_q) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          done_pend_d = 1'b0;
        end else if (tick) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            dac_data_d = fifo_rdata[I_LO +: DATA_WIDTH];
            q_hold_d   = fifo_rdata[Q_LO +: DATA_WIDTH];
            sel_d      = 1'b0;
            strobe_d   = 1'b1;
            if (ilv_q) state_d = EMIT_Q;
            else       pair_done = 1'b1;
          end else begin
            unr_d = 1'b1;
          end
        end
      end
      EMIT_Q: begin
        if (Cfg_Stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          dac_data_d = q_hold_q;
          sel_d      = 1'b1;
          strobe_d   = 1'b1;
          state_d    = EMIT_I;
          pair_done  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pair_done && !cont_q && rem_q != '0) begin
      rem_d = rem_q - 1'b1;
      if (rem_q == CNT_WIDTH'(1)) done_pend_d = 1'b1;
    end

    en_d = (state_d != IDLE);
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      div_cnt_q   <= '0;
      rem_q       <= '0;
      cont_q      <= 1'b0;
      ilv_q       <= 1'b0;
      done_pend_q <= 1'b0;
      q_hold_q    <= '0;
      dac_data_q  <= '0;
      strobe_q    <= 1'b0;
      sel_q       <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      unr_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      div_cnt_q   <= div_cnt_d;
      rem_q       <= rem_d;
      cont_q      <= cont_d;
      ilv_q       <= ilv_d;
      done_pend_q <= done_pend_d;
      q_hold_q    <= q_hold_d;
      dac_data_q  <= dac_data_d;
      strobe_q    <= strobe_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      done_q      <= done_d;
      unr_q       <= unr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign Smp_Full     = fifo_full;
  assign Smp_Level    = fifo_level;
  assign DAC_Data     = dac_data_q;
  assign DAC_Strobe   = strobe_q;
  assign DAC_Sel      = sel_q;
  assign DAC_En       = en_q;
  assign Sts_Busy     = (state_q != IDLE);
  assign Sts_Done     = done_q;
  assign Sts_Underrun = unr_q;
  assign Sts_Overflow = ovf_q;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Self-checking bench for dac_sample_sequencer; a queue of pushed pairs is the
// reference FIFO and expected strobe streams are derived from it per burst.
module tb_dac_sample_sequencer;
  localparam int DW = 10;
  localparam int DL = 4;
  localparam int VW = 16;
  localparam int CW = 16;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            Cfg_Start, Cfg_Stop, Cfg_Interleave, Smp_Wr;
  logic [VW-1:0]   Cfg_Div;
  logic [CW-1:0]   Cfg_Count;
  logic [0:2*DW-1] Smp_Data;
  logic            Smp_Full;
  logic [DL:0]     Smp_Level;
  logic [0:DW-1]   DAC_Data;
  logic            DAC_Strobe, DAC_Sel, DAC_En;
  logic            Sts_Busy, Sts_Done, Sts_Underrun, Sts_Overflow;

  int vectors = 0;
  int errors  = 0;
  logic [2*DW-1:0] mq[$];

  always #5 clk = ~clk;

  dac_sample_sequencer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .DIV_WIDTH(VW), .CNT_WIDTH(CW)) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Reset(rst),
    .Cfg_Start(Cfg_Start), .Cfg_Stop(Cfg_Stop), .Cfg_Div(Cfg_Div),
    .Cfg_Count(Cfg_Count), .Cfg_Interleave(Cfg_Interleave),
    .Smp_Wr(Smp_Wr), .Smp_Data(Smp_Data), .Smp_Full(Smp_Full), .Smp_Level(Smp_Level),
    .DAC_Data(DAC_Data), .DAC_Strobe(DAC_Strobe), .DAC_Sel(DAC_Sel), .DAC_En(DAC_En),
    .Sts_Busy(Sts_Busy), .Sts_Done(Sts_Done),
    .Sts_Underrun(Sts_Underrun), .Sts_Overflow(Sts_Overflow)
  );

  // All stimulus tasks begin and end at a falling edge.
  task automatic push(input logic [2*DW-1:0] p);
    Smp_Wr = 1'b1;
    Smp_Data = p;
    @(negedge clk);
    Smp_Wr = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(p);
  endtask

  task automatic start(input int div, input int cnt, input bit ilv);
    Cfg_Div = VW'(div);
    Cfg_Count = CW'(cnt);
    Cfg_Interleave = ilv;
    Cfg_Start = 1'b1;
    @(negedge clk);
    Cfg_Start = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (DAC_Data !== '0 || DAC_Strobe !== 1'b0 || DAC_Sel !== 1'b0 || DAC_En !== 1'b0) begin
      errors++;
      $display("FAIL reset_dac data=%h strobe=%b sel=%b en=%b required all 0", DAC_Data, DAC_Strobe, DAC_Sel, DAC_En);
    end
    vectors++;
    if (Sts_Busy !== 1'b0 || Sts_Done !== 1'b0 || Sts_Underrun !== 1'b0 || Sts_Overflow !== 1'b0 ||
        Smp_Full !== 1'b0 || Smp_Level !== '0) begin
      errors++;
      $display("FAIL reset_status busy=%b done=%b unr=%b ovf=%b full=%b level=%0d required all 0",
               Sts_Busy, Sts_Done, Sts_Underrun, Sts_Overflow, Smp_Full, Smp_Level);
    end
  endtask

  // Counted burst drawn from already-queued pairs; cnt must not exceed the queue.
  task automatic test_burst(input int div, input int cnt, input bit ilv);
    logic [DW-1:0]   ed[$];
    logic            es[$];
    logic [2*DW-1:0] p;
    int nw, w, last_s, limit;
    bit got_done;
    for (int k = 0; k < cnt; k++) begin
      p = mq.pop_front();
      ed.push_back(p[2*DW-1:DW]);
      es.push_back(1'b0);
      if (ilv) begin
        ed.push_back(p[DW-1:0]);
        es.push_back(1'b1);
      end
    end
    nw = ed.size();
    w = 0;
    last_s = 0;
    got_done = 1'b0;
    start(div, cnt, ilv);
    vectors++;
    if (DAC_En !== 1'b1 || Sts_Busy !== 1'b1) begin
      errors++;
      $display("FAIL burst_start en=%b busy=%b required 1/1", DAC_En, Sts_Busy);
    end
    vectors++;
    if (Sts_Underrun !== 1'b0 || Sts_Overflow !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear unr=%b ovf=%b required 0/0", Sts_Underrun, Sts_Overflow);
    end
    limit = nw * (div + 1) + 8;
    for (int s = 1; s <= limit && !got_done; s++) begin
      @(negedge clk);
      if (DAC_Strobe === 1'b1) begin
        vectors++;
        if (w >= nw) begin
          errors++;
          $display("FAIL burst_extra_strobe at step %0d data=%h required no strobe", s, DAC_Data);
        end else begin
          if (s != 1 + w * (div + 1)) begin
            errors++;
            $display("FAIL strobe_spacing word %0d at step %0d required step %0d", w, s, 1 + w * (div + 1));
          end
          vectors++;
          if (DAC_Data !== ed[w] || DAC_Sel !== es[w]) begin
            errors++;
            $display("FAIL strobe_data word %0d data=%h sel=%b required %h/%b", w, DAC_Data, DAC_Sel, ed[w], es[w]);
          end
          w++;
          last_s = s;
        end
      end
      if (Sts_Done === 1'b1) begin
        got_done = 1'b1;
        vectors++;
        if (w != nw || s != last_s + 1 || DAC_En !== 1'b0) begin
          errors++;
          $display("FAIL done_timing words=%0d step=%0d en=%b required %0d/%0d/0", w, s, DAC_En, nw, last_s + 1);
        end
      end
    end
    vectors++;
    if (!got_done) begin
      errors++;
      $display("FAIL burst_timeout words=%0d of %0d, no Done within %0d clocks", w, nw, limit);
    end
    vectors++;
    if (Smp_Level !== (DL+1)'(mq.size())) begin
      errors++;
      $display("FAIL burst_level level=%0d required %0d", Smp_Level, mq.size());
    end
    @(negedge clk);
    vectors++;
    if (Sts_Done !== 1'b0 || Sts_Busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b busy=%b required 0/0", Sts_Done, Sts_Busy);
    end
  endtask

  task automatic test_directed();
    push({10'h123, 10'h0AB});
    push({10'h3FF, 10'h001});
    test_burst(4, 2, 1'b1);
  endtask

  task automatic test_underrun();
    logic [2*DW-1:0] p;
    int strobes;
    bit seen;
    strobes = 0;
    start(1, 1, 1'b0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (DAC_Strobe === 1'b1) strobes++;
    end
    vectors++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL underrun_no_strobe strobes=%0d required 0", strobes);
    end
    vectors++;
    if (Sts_Underrun !== 1'b1 || Sts_Busy !== 1'b1) begin
      errors++;
      $display("FAIL underrun_flag unr=%b busy=%b required 1/1", Sts_Underrun, Sts_Busy);
    end
    push({10'h155, 10'($urandom())});
    p = mq.pop_front();
    seen = 1'b0;
    for (int s = 0; s < 6 && !seen; s++) begin
      @(negedge clk);
      if (DAC_Strobe === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || DAC_Data !== p[2*DW-1:DW] || DAC_Sel !== 1'b0) begin
      errors++;
      $display("FAIL underrun_recover seen=%b data=%h sel=%b required 1/%h/0", seen, DAC_Data, DAC_Sel, p[2*DW-1:DW]);
    end
    @(negedge clk);
    vectors++;
    if (Sts_Done !== 1'b1 || DAC_En !== 1'b0 || Sts_Underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_done done=%b en=%b unr=%b required 1/0/1", Sts_Done, DAC_En, Sts_Underrun);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < DEPTH + 1; k++) push(20'($urandom()));
    vectors++;
    if (Smp_Full !== 1'b1 || Smp_Level !== (DL+1)'(DEPTH) || Sts_Overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow full=%b level=%0d ovf=%b required 1/%0d/1", Smp_Full, Smp_Level, Sts_Overflow, DEPTH);
    end
    test_burst(0, DEPTH, 1'b0);
    vectors++;
    if (Smp_Full !== 1'b0 || Smp_Level !== '0) begin
      errors++;
      $display("FAIL overflow_drain full=%b level=%0d required 0/0", Smp_Full, Smp_Level);
    end
  endtask

  task automatic test_continuous_stop();
    logic [2*DW-1:0] p;
    bit seen;
    for (int k = 0; k < 8; k++) push(20'($urandom()));
    start(0, 0, 1'b1);
    seen = 1'b0;
    for (int s = 0; s < 4 && !seen; s++) begin
      @(negedge clk);
      if (DAC_Strobe === 1'b1) seen = 1'b1;
    end
    p = mq.pop_front();
    vectors++;
    if (!seen || DAC_Sel !== 1'b0 || DAC_Data !== p[2*DW-1:DW]) begin
      errors++;
      $display("FAIL cont_first seen=%b data=%h sel=%b required 1/%h/0", seen, DAC_Data, DAC_Sel, p[2*DW-1:DW]);
    end
    Cfg_Stop = 1'b1;
    @(negedge clk);
    Cfg_Stop = 1'b0;
    vectors++;
    if (DAC_Strobe !== 1'b0 || Sts_Done !== 1'b1 || DAC_En !== 1'b0 || Sts_Busy !== 1'b0) begin
      errors++;
      $display("FAIL stop strobe=%b done=%b en=%b busy=%b required 0/1/0/0", DAC_Strobe, Sts_Done, DAC_En, Sts_Busy);
    end
    vectors++;
    if (Smp_Level !== (DL+1)'(7)) begin
      errors++;
      $display("FAIL stop_level level=%0d required 7", Smp_Level);
    end
    test_burst($urandom_range(0, 2), 7, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) push(20'($urandom()));
      test_burst($urandom_range(0, 3), $urandom_range(1, mq.size()), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_and_start_stop();
    bit seen;
    int strobes;
    push(20'($urandom()));
    push(20'($urandom()));
    start(3, 0, 1'b1);
    seen = 1'b0;
    for (int s = 0; s < 6 && !seen; s++) begin
      @(negedge clk);
      if (DAC_Strobe === 1'b1 && DAC_Sel === 1'b0) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_reset_setup no I strobe within 6 clocks");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    test_reset();
    push(20'($urandom()));
    Cfg_Start = 1'b1;
    Cfg_Stop = 1'b1;
    @(negedge clk);
    Cfg_Start = 1'b0;
    Cfg_Stop = 1'b0;
    vectors++;
    if (Sts_Busy !== 1'b0 || DAC_En !== 1'b0 || Sts_Done !== 1'b0) begin
      errors++;
      $display("FAIL start_stop busy=%b en=%b done=%b required 0/0/0", Sts_Busy, DAC_En, Sts_Done);
    end
    strobes = 0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      if (DAC_Strobe === 1'b1) strobes++;
    end
    vectors++;
    if (strobes != 0 || Smp_Level !== (DL+1)'(1)) begin
      errors++;
      $display("FAIL start_stop_idle strobes=%0d level=%0d required 0/1", strobes, Smp_Level);
    end
  endtask

  initial begin
    rst = 1'b1;
    Cfg_Start = 1'b0;
    Cfg_Stop = 1'b0;
    Cfg_Div = '0;
    Cfg_Count = '0;
    Cfg_Interleave = 1'b0;
    Smp_Wr = 1'b0;
    Smp_Data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_directed();
    test_underrun();
    test_overflow();
    test_continuous_stop();
    test_random();
    test_reset_mid_and_start_stop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
